// File: rtl/mxalu_seq.sv
// Sliced multi-cycle ALU: one SLICE-bit slice per clock, LSB slice first.
// Latency: out_valid rises NSLICE cycles after the accepting edge.
// Backpressure: result held in DONE until out_ready; no accept until back in IDLE.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   cs_n               chip select (active low), gates acceptance only
//   in_valid/in_ready  request handshake; opcode, a, b, cin sampled on accept
//   out_valid/out_ready result handshake; f, cout, zero, a_b, ovf
// Build option: define MXALU_OVF_EN to compute signed overflow on ovf;
// otherwise ovf is tied to 0.
module mxalu_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             zero,
    output logic             a_b,
    output logic             ovf
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    generate
        if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_cfg
            $error("mxalu_seq: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    // Operands are shifted right one slice per RUN cycle so the active
    // slice always sits in the low SLICE bits.
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-1:0] f_acc;
    logic             carry;
    logic             zero_acc, ab_acc;
    logic [IW-1:0]    idx;

    logic             accept;
    logic             arith;
    logic [SLICE-1:0] a_s, b_s, bop_s, res_s;
    logic [SLICE:0]   sum_s;
    logic [WIDTH-1:0] f_nxt;
    logic             carry_init;

    assign accept = (state == IDLE) && in_valid && !cs_n;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !cs_n;
                if (in_valid && !cs_n) state_nxt = RUN;
            end
            RUN: begin
                if (idx == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Carry seeded at accept; subtraction variants run as A + ~B + c.
    always_comb begin
        carry_init = 1'b0;
        case (opcode)
            4'h9, 4'hC:  carry_init = 1'b1;
            4'hA, 4'hB:  carry_init = cin;
            default:     carry_init = 1'b0;
        endcase
    end

    // Current slice: effective B operand, adder and logic result.
    always_comb begin
        arith = op_r[3];
        a_s   = a_sh[SLICE-1:0];
        b_s   = b_sh[SLICE-1:0];
        case (op_r)
            4'h9, 4'hB, 4'hF: bop_s = ~b_s;
            4'hC:             bop_s = '0;
            4'hD:             bop_s = '1;
            4'hE:             bop_s = a_s;
            default:          bop_s = b_s;
        endcase
        sum_s = {1'b0, a_s} + {1'b0, bop_s} + {{SLICE{1'b0}}, carry};
        res_s = sum_s[SLICE-1:0];
        if (!arith) begin
            case (op_r[2:0])
                3'd0:    res_s = a_s;
                3'd1:    res_s = ~a_s;
                3'd2:    res_s = a_s & b_s;
                3'd3:    res_s = a_s | b_s;
                3'd4:    res_s = a_s ^ b_s;
                3'd5:    res_s = ~(a_s ^ b_s);
                3'd6:    res_s = a_s & ~b_s;
                default: res_s = '0;
            endcase
        end
        // New slice enters at the top; after NSLICE shifts slice 0 is at the LSB.
        f_nxt = (f_acc >> SLICE) | (WIDTH'(res_s) << (WIDTH - SLICE));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r     <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            f_acc    <= '0;
            carry    <= 1'b0;
            zero_acc <= 1'b0;
            ab_acc   <= 1'b0;
            idx      <= '0;
            f        <= '0;
            cout     <= 1'b0;
            zero     <= 1'b0;
            a_b      <= 1'b0;
        end else begin
            if (accept) begin
                op_r     <= opcode;
                a_sh     <= a;
                b_sh     <= b;
                carry    <= carry_init;
                zero_acc <= 1'b1;
                ab_acc   <= 1'b1;
                idx      <= '0;
            end else if (state == RUN) begin
                a_sh     <= a_sh >> SLICE;
                b_sh     <= b_sh >> SLICE;
                f_acc    <= f_nxt;
                carry    <= sum_s[SLICE];
                zero_acc <= zero_acc & (res_s == '0);
                ab_acc   <= ab_acc & (a_s == b_s);
                idx      <= idx + 1'b1;
                // Visible outputs only move on entry to DONE.
                if (idx == LAST) begin
                    f    <= f_nxt;
                    cout <= arith & sum_s[SLICE];
                    zero <= zero_acc & (res_s == '0);
                    a_b  <= ab_acc & (a_s == b_s);
                end
            end
        end
    end

`ifdef MXALU_OVF_EN
    // Same-sign operands producing a different-sign result is equivalent
    // to carry-into-MSB XOR carry-out-of-MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state == RUN && idx == LAST) begin
            ovf <= arith & (a_s[SLICE-1] == bop_s[SLICE-1])
                         & (res_s[SLICE-1] != a_s[SLICE-1]);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
